// File: rtl/branch_pc_unit.sv
// Next-PC / branch-resolution stage: owns the architectural PC, the fetch
// handshake, control-transfer traps and the retire/branch/taken counters.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int          CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             fetch_req_o,
  input  logic             fetch_ack_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic [31:0]      imm_i,
  input  logic [31:0]      rs1_i,
  output logic             br_unsign_o,
  input  logic             br_less_i,
  input  logic             br_equal_i,
  output logic             taken_o,
  output logic             retire_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [31:0]      trap_val_o,
  input  logic             trap_clr_i,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {RUN, TRAP} state_t;

  state_t      state_q;
  logic [31:0] pc_q;

  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic        br_legal;
  logic        br_cond;
  logic        transfer;
  logic        acked;
  logic        misaligned;
  logic        illegal;
  logic        retire;
  logic [31:0] target;
  logic [31:0] next_pc;

  always_comb begin
    is_branch = (opcode_i == OP_BRANCH);
    is_jal    = (opcode_i == OP_JAL);
    is_jalr   = (opcode_i == OP_JALR);
    br_legal  = (funct3_i != 3'b010) && (funct3_i != 3'b011);

    br_cond = 1'b0;
    case (funct3_i)
      3'b000:         br_cond = br_equal_i;
      3'b001:         br_cond = ~br_equal_i;
      3'b100, 3'b110: br_cond = br_less_i;
      3'b101, 3'b111: br_cond = ~br_less_i;
      default:        br_cond = 1'b0;
    endcase

    // JALR clears bit0 before the alignment check, so only bit1 can fault there.
    if (is_jalr) target = (rs1_i + imm_i) & ~32'h1;
    else         target = pc_q + imm_i;

    transfer   = is_jal || is_jalr || (is_branch && br_legal && br_cond);
    acked      = (state_q == RUN) && fetch_ack_i;
    misaligned = transfer && (target[1:0] != 2'b00);
    illegal    = is_branch && !br_legal;
    retire     = acked && !misaligned && !illegal;
    next_pc    = transfer ? target : pc_q + 32'd4;
  end

  assign br_unsign_o = is_branch && funct3_i[1];
  assign taken_o     = retire && transfer;
  assign retire_o    = retire;
  assign fetch_req_o = (state_q == RUN);
  assign trap_o      = (state_q == TRAP);
  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_q + 32'd4;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      trap_cause_o <= 2'd0;
      trap_val_o   <= 32'd0;
      retire_cnt_o <= '0;
      branch_cnt_o <= '0;
      taken_cnt_o  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (acked) begin
            if (misaligned) begin
              state_q      <= TRAP;
              trap_cause_o <= 2'd1;
              trap_val_o   <= target;
            end else if (illegal) begin
              state_q      <= TRAP;
              trap_cause_o <= 2'd2;
              trap_val_o   <= pc_q;
            end else begin
              pc_q         <= next_pc;
              retire_cnt_o <= retire_cnt_o + CNT_W'(1);
              if (is_branch) branch_cnt_o <= branch_cnt_o + CNT_W'(1);
              if (is_branch && transfer) taken_cnt_o <= taken_cnt_o + CNT_W'(1);
            end
          end
        end
        TRAP: begin
          if (trap_clr_i) begin
            state_q      <= RUN;
            pc_q         <= TRAP_VECTOR;
            trap_cause_o <= 2'd0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: directed scenarios followed by random instruction
// streams, all checked against an architectural model of the PC stage.
module tb_branch_pc_unit;

  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;
  localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
  localparam logic [6:0]  OP_JAL      = 7'b1101111;
  localparam logic [6:0]  OP_JALR     = 7'b1100111;
  localparam logic [6:0]  OP_ALU      = 7'b0010011;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_req_o;
  logic        fetch_ack_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] imm_i = '0;
  logic [31:0] rs1_i = '0;
  logic        br_unsign_o;
  logic        br_less_i = 1'b0;
  logic        br_equal_i = 1'b0;
  logic        taken_o;
  logic        retire_o;
  logic        trap_o;
  logic [1:0]  trap_cause_o;
  logic [31:0] trap_val_o;
  logic        trap_clr_i = 1'b0;
  logic [31:0] retire_cnt_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] taken_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model state
  logic [31:0] m_pc;
  logic        m_trap;
  logic [1:0]  m_cause;
  logic [31:0] m_val;
  logic [31:0] m_retire, m_branch, m_taken;

  branch_pc_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fetch_req_o(fetch_req_o), .fetch_ack_i(fetch_ack_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .imm_i(imm_i), .rs1_i(rs1_i), .br_unsign_o(br_unsign_o), .br_less_i(br_less_i),
    .br_equal_i(br_equal_i), .taken_o(taken_o), .retire_o(retire_o), .trap_o(trap_o),
    .trap_cause_o(trap_cause_o), .trap_val_o(trap_val_o), .trap_clr_i(trap_clr_i),
    .retire_cnt_o(retire_cnt_o), .branch_cnt_o(branch_cnt_o), .taken_cnt_o(taken_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pc = 32'h0; m_trap = 1'b0; m_cause = 2'd0; m_val = 32'h0;
    m_retire = 0; m_branch = 0; m_taken = 0;
  endtask

  task automatic checkState();
    checkOutput("pc", pc_o, m_pc);
    checkOutput("pc_plus4", pc_plus4_o, m_pc + 32'd4);
    checkOutput("fetch_req", 32'(fetch_req_o), 32'(!m_trap));
    checkOutput("trap", 32'(trap_o), 32'(m_trap));
    checkOutput("trap_cause", 32'(trap_cause_o), 32'(m_cause));
    checkOutput("trap_val", trap_val_o, m_val);
    checkOutput("retire_cnt", retire_cnt_o, m_retire);
    checkOutput("branch_cnt", branch_cnt_o, m_branch);
    checkOutput("taken_cnt", taken_cnt_o, m_taken);
  endtask

  // One clock of stimulus: drive at the falling edge, check mid-cycle, then
  // advance the model across the rising edge.
  task automatic applyStimulus(input logic ack, input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] imm, input logic [31:0] rs1,
                               input logic less, input logic equal, input logic clr);
    logic is_br, is_jal, is_jalr, legal, cond, xfer, mis, ill, acked, e_ret, e_tak, e_uns;
    logic [31:0] tgt;
    @(negedge clk_i);
    fetch_ack_i = ack; opcode_i = op; funct3_i = f3; imm_i = imm; rs1_i = rs1;
    br_less_i = less; br_equal_i = equal; trap_clr_i = clr;
    #1;
    is_br   = (op == OP_BRANCH);
    is_jal  = (op == OP_JAL);
    is_jalr = (op == OP_JALR);
    legal   = !(f3 == 3'd2 || f3 == 3'd3);
    case (f3)
      3'd0: cond = equal;
      3'd1: cond = !equal;
      3'd4, 3'd6: cond = less;
      3'd5, 3'd7: cond = !less;
      default: cond = 1'b0;
    endcase
    e_uns = is_br ? f3[1] : 1'b0;
    xfer  = is_jal || is_jalr || (is_br && legal && cond);
    tgt   = is_jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (m_pc + imm);
    mis   = xfer && (tgt % 4 != 0);
    ill   = is_br && !legal;
    acked = ack && !m_trap;
    e_ret = acked && !mis && !ill;
    e_tak = e_ret && xfer;
    checkState();
    checkOutput("br_unsign", 32'(br_unsign_o), 32'(e_uns));
    checkOutput("taken", 32'(taken_o), 32'(e_tak));
    checkOutput("retire", 32'(retire_o), 32'(e_ret));
    @(posedge clk_i);
    if (m_trap) begin
      if (clr) begin m_trap = 1'b0; m_cause = 2'd0; m_pc = TRAP_VECTOR; end
    end else if (acked) begin
      if (mis) begin m_trap = 1'b1; m_cause = 2'd1; m_val = tgt; end
      else if (ill) begin m_trap = 1'b1; m_cause = 2'd2; m_val = m_pc; end
      else begin
        m_retire++;
        if (is_br) m_branch++;
        if (is_br && xfer) m_taken++;
        m_pc = xfer ? tgt : m_pc + 32'd4;
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clk_i);
    rst_ni = 1'b0; fetch_ack_i = 1'b0; trap_clr_i = 1'b0;
    #1;
    modelReset();
    checkState();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [31:0] a, b, imm, rs1;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        uns, less;

    modelReset();
    applyReset();

    // Wait states after reset
    repeat (3) applyStimulus(1'b0, OP_ALU, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_JAL, 3'd0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0);

    // BEQ taken then, after jumping back, not taken
    applyStimulus(1'b1, OP_BRANCH, 3'd0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_JAL, 3'd0, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_BRANCH, 3'd0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);

    // Signedness select and BGEU backwards at 0x100
    applyStimulus(1'b0, OP_BRANCH, 3'd6, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_BRANCH, 3'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_JAL, 3'd0, 32'h0000_00BC, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_BRANCH, 3'd7, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0, 1'b0);

    // JALR to 0x2002 traps; acks are ignored while trapped; clear resumes at vector
    applyStimulus(1'b1, OP_JALR, 3'd0, 32'h2, 32'h2001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_ALU, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_ALU, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Illegal funct3 at 0x80, then reset while trapped
    applyStimulus(1'b1, OP_JAL, 3'd0, 32'hFFFF_FF80, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_BRANCH, 3'd2, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, OP_ALU, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyReset();
    applyStimulus(1'b0, OP_ALU, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // PC wrap from 0xFFFF_FFFC
    applyStimulus(1'b1, OP_JALR, 3'd0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_ALU, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_ALU, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Random instruction stream with comparator flags derived from random operands
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: op = OP_BRANCH;
        1: op = OP_JAL;
        2: op = OP_JALR;
        default: op = OP_ALU;
      endcase
      f3  = 3'($urandom_range(0, 7));
      imm = $urandom;
      rs1 = $urandom;
      if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) rs1[1] = 1'b0;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      uns  = (op == OP_BRANCH) && f3[1];
      less = uns ? (a < b) : ($signed(a) < $signed(b));
      applyStimulus($urandom_range(0, 3) != 0, op, f3, imm, rs1, less, a == b,
                    $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
